fnd_scan_driver: RTL and testbench

- Downstream display stage of the up/down counter path: takes the 14-bit binary count (0..9999) and time-multiplexes it onto the 4-digit common-anode 7-segment display.
- Contains its own scan-rate divider, a frame-coherent data snapshot, a binary-to-decimal digit split and a segment decoder. All outputs are registered.
- Sits between the counter block and the board FND pins.

---
 rtl/fnd_scan_driver_if.sv | 27 ++
 rtl/fnd_scan_driver.sv | 123 ++++++++++++
 tb/tb_fnd_scan_driver.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_driver_if.sv
// rtl/fnd_scan_driver_if.sv - display-value and FND pin bundle for fnd_scan_driver
//
// Signals:
//   fndData  [13:0] unsigned binary value to display (driven by the counter side)
//   fndCom   [3:0]  digit enables, active-low, bit0 = ones .. bit3 = thousands
//   fndFont  [7:0]  segments {dp,g,f,e,d,c,b,a}, active-low
// Modports:
//   master - value source / pin observer (drives fndData)
//   slave  - the scan driver (drives fndCom, fndFont)

interface fnd_scan_driver_if;
    logic [13:0] fndData;
    logic [3:0]  fndCom;
    logic [7:0]  fndFont;

    modport master (
        output fndData,
        input  fndCom,
        input  fndFont
    );

    modport slave (
        input  fndData,
        output fndCom,
        output fndFont
    );
endinterface

// File: rtl/fnd_scan_driver.sv
// rtl/fnd_scan_driver.sv - 4-digit common-anode 7-segment scan driver with frame snapshot
//
// Purpose:
//   Time-multiplexes a 14-bit binary value (0..9999) onto a 4-digit FND.
//   Each digit is held for N = CLK_HZ/SCAN_HZ clocks; scan order is ones,
//   tens, hundreds, thousands. The input is captured once per frame so a
//   frame never mixes two values. Values above MAX_VAL show dashes.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-low
//   bus  - fnd_scan_driver_if.slave (fndData in, fndCom/fndFont out, all outputs registered)
// Optional build macro:
//   FND_LZB_EN - blank leading zeros of in-range values (digit0 always shown)

module fnd_scan_driver #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000,
    parameter int MAX_VAL = 9999
) (
    input  logic               clk,
    input  logic               rst,
    fnd_scan_driver_if.slave   bus
);

    localparam int N     = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = (N > 2) ? $clog2(N) : 1;

    // Internal digit codes beyond 0..9
    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       sel_q, sel_d;
    logic [13:0]      shadow_q, shadow_d;
    logic [3:0]       com_q, com_d;
    logic [7:0]       font_q, font_d;

    logic [3:0]       dig [4];
    logic             ovf;
    logic             blank;
    logic [3:0]       code;

    function automatic logic [7:0] seg_font(input logic [3:0] c);
        case (c)
            4'd0:    seg_font = 8'hC0;
            4'd1:    seg_font = 8'hF9;
            4'd2:    seg_font = 8'hA4;
            4'd3:    seg_font = 8'hB0;
            4'd4:    seg_font = 8'h99;
            4'd5:    seg_font = 8'h92;
            4'd6:    seg_font = 8'h82;
            4'd7:    seg_font = 8'hF8;
            4'd8:    seg_font = 8'h80;
            4'd9:    seg_font = 8'h90;
            4'hA:    seg_font = 8'hBF;
            default: seg_font = 8'hFF;
        endcase
    endfunction

    always_comb begin
        div_d    = div_q + 1'b1;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        if (div_q == DIV_W'(N - 1)) begin
            div_d = '0;
            sel_d = sel_q + 2'd1;
            // Capture the new value only at the thousands->ones wrap so the
            // following frame is built from a single coherent value.
            if (sel_q == 2'd3) begin
                shadow_d = bus.fndData;
            end
        end

        dig[0] = 4'(shadow_q % 14'd10);
        dig[1] = 4'((shadow_q / 14'd10) % 14'd10);
        dig[2] = 4'((shadow_q / 14'd100) % 14'd10);
        dig[3] = 4'((shadow_q / 14'd1000) % 14'd10);

        ovf = (shadow_q > 14'(MAX_VAL));

`ifdef FND_LZB_EN
        // Blank a digit when every more-significant digit is zero too;
        // overflow dashes are never blanked.
        blank = !ovf && (((sel_q == 2'd3) && (shadow_q < 14'd1000)) ||
                         ((sel_q == 2'd2) && (shadow_q < 14'd100))  ||
                         ((sel_q == 2'd1) && (shadow_q < 14'd10)));
`else
        blank = 1'b0;
`endif

        if (ovf) begin
            code = CODE_DASH;
        end else if (blank) begin
            code = CODE_BLANK;
        end else begin
            code = dig[sel_q];
        end

        // Outputs follow the current sel, so a sel change shows one cycle later.
        com_d  = ~(4'b0001 << sel_q);
        font_d = seg_font(code);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q    <= '0;
            sel_q    <= 2'd0;
            shadow_q <= 14'd0;
            com_q    <= 4'b1111;
            font_q   <= 8'hFF;
        end else begin
            div_q    <= div_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            com_q    <= com_d;
            font_q   <= font_d;
        end
    end

    assign bus.fndCom  = com_q;
    assign bus.fndFont = font_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb/tb_fnd_scan_driver.sv - directed self-checking bench for fnd_scan_driver (N = 4)

module tb_fnd_scan_driver;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    fnd_scan_driver_if bus_if ();

    fnd_scan_driver #(
        .CLK_HZ  (40),
        .SCAN_HZ (10),
        .MAX_VAL (9999)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit enable for each scan position, ones first.
    logic [3:0] com_tab [4];
    initial begin
        com_tab[0] = 4'b1110;
        com_tab[1] = 4'b1101;
        com_tab[2] = 4'b1011;
        com_tab[3] = 4'b0111;
    end

    // Entered at time 0; leaves at the negedge after the first active edge.
    task automatic test_reset;
        rst            = 1'b0;
        bus_if.fndData = 14'd1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({bus_if.fndCom, bus_if.fndFont} !== {4'b1111, 8'hFF})
                $display("FAIL reset_hold[%0d] got %b/%h want 1111/ff", i, bus_if.fndCom, bus_if.fndFont);
            else n_pass++;
        end
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus_if.fndCom, bus_if.fndFont} !== {4'b1111, 8'hFF})
            $display("FAIL reset_release got %b/%h want 1111/ff", bus_if.fndCom, bus_if.fndFont);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus_if.fndCom, bus_if.fndFont} !== {4'b1110, 8'hC0})
            $display("FAIL reset_first_digit got %b/%h want 1110/c0", bus_if.fndCom, bus_if.fndFont);
        else n_pass++;
    endtask

    // Rest of frame 0 shows 0000, then two frames of 1234.
    task automatic test_scan;
        logic [7:0] f [4];
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (k != 0 || c != 0) begin
                    @(negedge clk);
                    n_total++;
                    if ({bus_if.fndCom, bus_if.fndFont} !== {com_tab[k], 8'hC0})
                        $display("FAIL scan_frame0 k=%0d c=%0d got %b/%h want %b/c0", k, c, bus_if.fndCom, bus_if.fndFont, com_tab[k]);
                    else n_pass++;
                end
            end
        end
        f[0] = 8'h99; f[1] = 8'hB0; f[2] = 8'hA4; f[3] = 8'hF9;
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    n_total++;
                    if ({bus_if.fndCom, bus_if.fndFont} !== {com_tab[k], f[k]})
                        $display("FAIL scan_1234 fr=%0d k=%0d c=%0d got %b/%h want %b/%h", fr, k, c, bus_if.fndCom, bus_if.fndFont, com_tab[k], f[k]);
                    else n_pass++;
                end
            end
        end
    endtask

    // Input changes while digit1 is shown; the frame stays on 1234.
    task automatic test_coherence;
        logic [7:0] f [4];
        logic [7:0] g [4];
        f[0] = 8'h99; f[1] = 8'hB0; f[2] = 8'hA4; f[3] = 8'hF9;
        g[0] = 8'h80; g[1] = 8'hF8; g[2] = 8'h82; g[3] = 8'h92;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (k == 1 && c == 0) bus_if.fndData = 14'd5678;
                n_total++;
                if ({bus_if.fndCom, bus_if.fndFont} !== {com_tab[k], f[k]})
                    $display("FAIL coherence_old k=%0d c=%0d got %b/%h want %b/%h", k, c, bus_if.fndCom, bus_if.fndFont, com_tab[k], f[k]);
                else n_pass++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                n_total++;
                if ({bus_if.fndCom, bus_if.fndFont} !== {com_tab[k], g[k]})
                    $display("FAIL coherence_new k=%0d c=%0d got %b/%h want %b/%h", k, c, bus_if.fndCom, bus_if.fndFont, com_tab[k], g[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow;
        bus_if.fndData = 14'd10000;
        // Frame still built from 5678; only the scan order is checked here.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                n_total++;
                if (bus_if.fndCom !== com_tab[k])
                    $display("FAIL overflow_lead_com k=%0d got %b want %b", k, bus_if.fndCom, com_tab[k]);
                else n_pass++;
            end
        end
        bus_if.fndData = 14'd16383;
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    if (fr == 0 && k == 0 && c == 0) bus_if.fndData = 14'd16383;
                    if (fr == 1 && k == 0 && c == 0) bus_if.fndData = 14'd9999;
                    n_total++;
                    if ({bus_if.fndCom, bus_if.fndFont} !== {com_tab[k], 8'hBF})
                        $display("FAIL overflow_dash fr=%0d k=%0d got %b/%h want %b/bf", fr, k, bus_if.fndCom, bus_if.fndFont, com_tab[k]);
                    else n_pass++;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                n_total++;
                if ({bus_if.fndCom, bus_if.fndFont} !== {com_tab[k], 8'h90})
                    $display("FAIL max_9999 k=%0d got %b/%h want %b/90", k, bus_if.fndCom, bus_if.fndFont, com_tab[k]);
                else n_pass++;
            end
        end
    endtask

    // Reset pulse while digit2 is being scanned; scan restarts at digit0 with 0000.
    task automatic test_mid_reset;
        for (int i = 0; i < 9; i++) @(negedge clk);
        n_total++;
        if (bus_if.fndCom !== 4'b1011)
            $display("FAIL midreset_pre got %b want 1011", bus_if.fndCom);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({bus_if.fndCom, bus_if.fndFont} !== {4'b1111, 8'hFF})
            $display("FAIL midreset_hold got %b/%h want 1111/ff", bus_if.fndCom, bus_if.fndFont);
        else n_pass++;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if ({bus_if.fndCom, bus_if.fndFont} !== {4'b1110, 8'hC0})
                $display("FAIL midreset_digit0 c=%0d got %b/%h want 1110/c0", c, bus_if.fndCom, bus_if.fndFont);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({bus_if.fndCom, bus_if.fndFont} !== {4'b1101, 8'hC0})
            $display("FAIL midreset_digit1 got %b/%h want 1101/c0", bus_if.fndCom, bus_if.fndFont);
        else n_pass++;
    endtask

    task automatic test_lzb;
        logic [7:0] f [4];
        bus_if.fndData = 14'd7;
        // Finish the current frame (5 of 16 cycles already consumed).
        for (int i = 0; i < 11; i++) @(negedge clk);
`ifdef FND_LZB_EN
        f[0] = 8'hF8; f[1] = 8'hFF; f[2] = 8'hFF; f[3] = 8'hFF;
`else
        f[0] = 8'hF8; f[1] = 8'hC0; f[2] = 8'hC0; f[3] = 8'hC0;
`endif
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                n_total++;
                if ({bus_if.fndCom, bus_if.fndFont} !== {com_tab[k], f[k]})
                    $display("FAIL lzb_7 k=%0d c=%0d got %b/%h want %b/%h", k, c, bus_if.fndCom, bus_if.fndFont, com_tab[k], f[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_scan();
        test_coherence();
        test_overflow();
        test_mid_reset();
        test_lzb();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
